// File: rtl/lda_pkg.sv
// lda_pkg: shared types and width helper for the lda_stream line rasteriser.
package lda_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_e;

    typedef enum logic {STEP_POS = 1'b0, STEP_NEG = 1'b1} step_e;

    function automatic int err_w(input int xw, input int yw);
        return (xw > yw ? xw : yw) + 2;
    endfunction

endpackage

// File: rtl/lda_octant_norm.sv
// lda_octant_norm: folds any line into a major-axis-increasing form for Bresenham stepping.
// LDA_SKIP_LAST_EN keeps input endpoint order so the walk always ends on (x1,y1).
module lda_octant_norm
    import lda_pkg::*;
#(
    parameter  int X_W = 9,
    parameter  int Y_W = 8,
    localparam int C_W = (X_W > Y_W) ? X_W : Y_W,
    localparam int E_W = err_w(X_W, Y_W)
) (
    input  logic [X_W-1:0]        x0,
    input  logic [X_W-1:0]        x1,
    input  logic [Y_W-1:0]        y0,
    input  logic [Y_W-1:0]        y1,
    output logic                  steep,
    output logic [C_W-1:0]        a0,
    output logic [C_W-1:0]        a1,
    output logic [C_W-1:0]        b0,
    output logic signed [E_W-1:0] dx,
    output logic signed [E_W-1:0] dy,
    output step_e                 astep,
    output step_e                 ystep
);

    logic [C_W-1:0]        ex0, ex1, ey0, ey1, pa0, pa1, pb0, pb1, b1;
    logic signed [E_W-1:0] adx, ady;
    logic                  swap;

    function automatic logic signed [E_W-1:0] absd(input logic [C_W-1:0] p, input logic [C_W-1:0] q);
        logic signed [E_W-1:0] d;
        d = $signed({2'b00, p}) - $signed({2'b00, q});
        return (d < 0) ? -d : d;
    endfunction

    always_comb begin
        ex0   = C_W'(x0);
        ex1   = C_W'(x1);
        ey0   = C_W'(y0);
        ey1   = C_W'(y1);
        adx   = absd(ex1, ex0);
        ady   = absd(ey1, ey0);
        steep = ady > adx;
        pa0   = steep ? ey0 : ex0;
        pa1   = steep ? ey1 : ex1;
        pb0   = steep ? ex0 : ey0;
        pb1   = steep ? ex1 : ey1;
`ifdef LDA_SKIP_LAST_EN
        swap  = 1'b0;
`else
        swap  = pa0 > pa1;
`endif
        a0    = swap ? pa1 : pa0;
        a1    = swap ? pa0 : pa1;
        b0    = swap ? pb1 : pb0;
        b1    = swap ? pb0 : pb1;
        dx    = absd(a1, a0);
        dy    = absd(b1, b0);
        astep = (a1 >= a0) ? STEP_POS : STEP_NEG;
        ystep = (b1 >= b0) ? STEP_POS : STEP_NEG;
    end

endmodule

// File: rtl/lda_stream.sv
// lda_stream: Bresenham line rasteriser emitting one pixel per plot/plot_ready handshake.
// Define LDA_SKIP_LAST_EN to omit the final endpoint (x1,y1) for polyline chaining.
module lda_stream
    import lda_pkg::*;
#(
    parameter  int X_W      = 9,
    parameter  int Y_W      = 8,
    parameter  int COLOUR_W = 3,
    localparam int C_W      = (X_W > Y_W) ? X_W : Y_W,
    localparam int ERR_W    = err_w(X_W, Y_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y0,
    input  logic [Y_W-1:0]      y1,
    input  logic [COLOUR_W-1:0] i_colour,
    output logic                busy,
    output logic                done,
    output logic                plot,
    input  logic                plot_ready,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] o_colour
);

    state_e                  state_q, state_d;
    logic [X_W-1:0]          x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0]          y0_q, y0_d, y1_q, y1_d;
    logic [COLOUR_W-1:0]     colour_q, colour_d;
    logic                    steep_q, steep_d;
    logic [C_W-1:0]          a_q, a_d, b_q, b_d, a1_q, a1_d;
    logic signed [ERR_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    step_e                   astep_q, astep_d, ystep_q, ystep_d;

    logic                    n_steep, hs, last;
    logic [C_W-1:0]          n_a0, n_a1, n_b0, a_nxt;
    logic signed [ERR_W-1:0] n_dx, n_dy, sum;
    step_e                   n_astep, n_ystep;

    lda_octant_norm #(.X_W(X_W), .Y_W(Y_W)) u_norm (
        .x0    (x0_q),
        .x1    (x1_q),
        .y0    (y0_q),
        .y1    (y1_q),
        .steep (n_steep),
        .a0    (n_a0),
        .a1    (n_a1),
        .b0    (n_b0),
        .dx    (n_dx),
        .dy    (n_dy),
        .astep (n_astep),
        .ystep (n_ystep)
    );

    assign hs    = (state_q == DRAW) && plot_ready;
    assign a_nxt = (astep_q == STEP_NEG) ? a_q - 1'b1 : a_q + 1'b1;
    assign sum   = err_q + dy_q;
`ifdef LDA_SKIP_LAST_EN
    assign last  = a_nxt == a1_q;
`else
    assign last  = a_q == a1_q;
`endif

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        colour_d = colour_q;
        steep_d  = steep_q;
        a_d      = a_q;
        b_d      = b_q;
        a1_d     = a1_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        astep_d  = astep_q;
        ystep_d  = ystep_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETUP;
                    x0_d     = x0;
                    x1_d     = x1;
                    y0_d     = y0;
                    y1_d     = y1;
                    colour_d = i_colour;
                end
            end
            SETUP: begin
`ifdef LDA_SKIP_LAST_EN
                state_d = (n_a0 == n_a1) ? DONE : DRAW;
`else
                state_d = DRAW;
`endif
                steep_d = n_steep;
                a_d     = n_a0;
                b_d     = n_b0;
                a1_d    = n_a1;
                dx_d    = n_dx;
                dy_d    = n_dy;
                err_d   = -(n_dx >>> 1);
                astep_d = n_astep;
                ystep_d = n_ystep;
            end
            DRAW: begin
                if (hs && last) begin
                    state_d = DONE;
                end else if (hs) begin
                    a_d   = a_nxt;
                    b_d   = (sum > 0) ? ((ystep_q == STEP_NEG) ? b_q - 1'b1 : b_q + 1'b1) : b_q;
                    err_d = (sum > 0) ? sum - dx_q : sum;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            colour_q <= '0;
            steep_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            a1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            astep_q  <= STEP_POS;
            ystep_q  <= STEP_POS;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            colour_q <= colour_d;
            steep_q  <= steep_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a1_q     <= a1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            astep_q  <= astep_d;
            ystep_q  <= ystep_d;
        end
    end

    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign plot     = state_q == DRAW;
    assign x        = X_W'(steep_q ? b_q : a_q);
    assign y        = Y_W'(steep_q ? a_q : b_q);
    assign o_colour = colour_q;

endmodule

// File: tb/tb_lda_stream.sv
// tb_lda_stream: directed self-checking bench for lda_stream with hand-derived pixel lists.
module tb_lda_stream;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           reset, start, plot_ready, busy, done, plot;
    logic [X_W-1:0] x0, x1, x;
    logic [Y_W-1:0] y0, y1, y;
    logic [CW-1:0]  i_colour, o_colour;

    int tests = 0;
    int fails = 0;
    int px[$], py[$], pc[$], pk[$];
    int done_cyc, done_cnt, stall_err;

    always #5 clk = ~clk;

    lda_stream #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .i_colour   (i_colour),
        .busy       (busy),
        .done       (done),
        .plot       (plot),
        .plot_ready (plot_ready),
        .x          (x),
        .y          (y),
        .o_colour   (o_colour)
    );

    // cycle 0 is the cycle start is high; bp selects ready only on cycles 2,5,8,...
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input bit bp, input int budget);
        int cyc;
        bit prev_stall;
        logic [X_W-1:0] lx;
        logic [Y_W-1:0] ly;
        logic [CW-1:0]  lc;
        px.delete(); py.delete(); pc.delete(); pk.delete();
        done_cyc = -1; done_cnt = 0; stall_err = 0; prev_stall = 0;
        lx = '0; ly = '0; lc = '0;
        @(negedge clk);
        start = 1'b1; x0 = X_W'(ax0); y0 = Y_W'(ay0); x1 = X_W'(ax1); y1 = Y_W'(ay1);
        i_colour = CW'(col); plot_ready = !bp;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            plot_ready = bp ? (cyc % 3 == 2) : 1'b1;
            if (prev_stall && (plot !== 1'b1 || x !== lx || y !== ly || o_colour !== lc)) stall_err++;
            if (plot && plot_ready) begin
                px.push_back(int'(x)); py.push_back(int'(y)); pc.push_back(int'(o_colour)); pk.push_back(cyc);
            end
            prev_stall = plot && !plot_ready;
            lx = x; ly = y; lc = o_colour;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; plot_ready = 1'b1;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; i_colour = '0;
        repeat (3) @(negedge clk);
        tests++; if (plot !== 1'b0) begin fails++; $display("FAIL reset_plot got %b want 0", plot); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if ({x, y, o_colour} !== '0) begin fails++; $display("FAIL reset_outs got x=%0d y=%0d c=%0d want 0", x, y, o_colour); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_horizontal;
        run_line(0, 0, 4, 0, 5, 1'b0, 40);
        tests++; if (px.size() !== 5) begin fails++; $display("FAIL horiz_count got %0d want 5", px.size()); end
        for (int i = 0; i < px.size() && i < 5; i++) begin
            tests++;
            if (px[i] !== i || py[i] !== 0 || pc[i] !== 5) begin
                fails++; $display("FAIL horiz_pix%0d got (%0d,%0d,c%0d) want (%0d,0,c5)", i, px[i], py[i], pc[i], i);
            end
        end
        tests++; if (pk.size() == 0 || pk[0] !== 2) begin fails++; $display("FAIL horiz_latency got %0d want 2", pk.size() ? pk[0] : -1); end
        tests++; if (done_cyc !== 7) begin fails++; $display("FAIL horiz_done_cyc got %0d want 7", done_cyc); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL horiz_done_width got %0d want 1", done_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL horiz_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_steep;
        int ex[7] = '{2, 2, 3, 3, 3, 4, 4};
        run_line(2, 1, 4, 7, 6, 1'b0, 40);
        tests++; if (px.size() !== 7) begin fails++; $display("FAIL steep_count got %0d want 7", px.size()); end
        for (int i = 0; i < px.size() && i < 7; i++) begin
            tests++;
            if (px[i] !== ex[i] || py[i] !== i + 1) begin
                fails++; $display("FAIL steep_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], i + 1);
            end
        end
        tests++; if (done_cyc !== 9) begin fails++; $display("FAIL steep_done_cyc got %0d want 9", done_cyc); end
    endtask

    task automatic test_reverse;
        int ey[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
        run_line(10, 5, 0, 0, 1, 1'b0, 40);
        tests++; if (px.size() !== 11) begin fails++; $display("FAIL rev_count got %0d want 11", px.size()); end
        for (int i = 0; i < px.size() && i < 11; i++) begin
            tests++;
            if (px[i] !== i || py[i] !== ey[i]) begin
                fails++; $display("FAIL rev_pix%0d got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], i, ey[i]);
            end
        end
        tests++; if (done_cyc !== 13) begin fails++; $display("FAIL rev_done_cyc got %0d want 13", done_cyc); end
    endtask

    task automatic test_backpressure;
        int ek[4] = '{2, 5, 8, 11};
        run_line(0, 0, 3, 3, 7, 1'b1, 60);
        tests++; if (px.size() !== 4) begin fails++; $display("FAIL bp_count got %0d want 4", px.size()); end
        for (int i = 0; i < px.size() && i < 4; i++) begin
            tests++;
            if (px[i] !== i || py[i] !== i || pc[i] !== 7 || pk[i] !== ek[i]) begin
                fails++; $display("FAIL bp_pix%0d got (%0d,%0d,c%0d)@%0d want (%0d,%0d,c7)@%0d", i, px[i], py[i], pc[i], pk[i], i, i, ek[i]);
            end
        end
        tests++; if (stall_err !== 0) begin fails++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_err); end
        tests++; if (done_cyc !== 12) begin fails++; $display("FAIL bp_done_cyc got %0d want 12", done_cyc); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL bp_done_width got %0d want 1", done_cnt); end
    endtask

    task automatic test_degenerate;
        run_line(7, 7, 7, 7, 2, 1'b0, 20);
`ifdef LDA_SKIP_LAST_EN
        tests++; if (px.size() !== 0) begin fails++; $display("FAIL degen_count got %0d want 0", px.size()); end
        tests++; if (done_cyc !== 2) begin fails++; $display("FAIL degen_done_cyc got %0d want 2", done_cyc); end
`else
        tests++; if (px.size() !== 1) begin fails++; $display("FAIL degen_count got %0d want 1", px.size()); end
        tests++; if (px.size() == 0 || px[0] !== 7 || py[0] !== 7) begin fails++; $display("FAIL degen_pix got (%0d,%0d) want (7,7)", px.size() ? px[0] : -1, py.size() ? py[0] : -1); end
        tests++; if (done_cyc !== 3) begin fails++; $display("FAIL degen_done_cyc got %0d want 3", done_cyc); end
`endif
    endtask

    task automatic test_reset_mid_line;
        int n;
        int extra;
        @(negedge clk);
        start = 1'b1; x0 = 9'd0; y0 = 8'd0; x1 = 9'd511; y1 = 8'd255; i_colour = 3'd3; plot_ready = 1'b1;
        n = 0;
        for (int c = 1; c < 20 && n < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (plot) n++;
        end
        tests++; if (n !== 3) begin fails++; $display("FAIL rst_reach_pix3 got %0d want 3", n); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_ctrl got plot=%b busy=%b done=%b want 000", plot, busy, done); end
        tests++; if ({x, y, o_colour} !== '0) begin fails++; $display("FAIL rst_outs got x=%0d y=%0d c=%0d want 0", x, y, o_colour); end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (plot || busy) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL rst_abandoned got %0d active cycles want 0", extra); end
        run_line(0, 0, 511, 255, 4, 1'b0, 600);
        tests++; if (px.size() !== 512) begin fails++; $display("FAIL long_count got %0d want 512", px.size()); end
        tests++; if (px.size() == 0 || px[0] !== 0 || py[0] !== 0) begin fails++; $display("FAIL long_first got (%0d,%0d) want (0,0)", px.size() ? px[0] : -1, py.size() ? py[0] : -1); end
        tests++; if (px.size() == 0 || px[px.size()-1] !== 511 || py[py.size()-1] !== 255) begin fails++; $display("FAIL long_last got (%0d,%0d) want (511,255)", px.size() ? px[px.size()-1] : -1, py.size() ? py[py.size()-1] : -1); end
        tests++; if (done_cyc !== 514) begin fails++; $display("FAIL long_done_cyc got %0d want 514", done_cyc); end
    endtask

    // start held high across a whole line: ignored while busy, accepted right after DONE
    task automatic test_back_to_back;
        int ex[5] = '{0, 1, 2, 5, 5};
        int ey[5] = '{0, 0, 0, 5, 6};
        int ec[5] = '{5, 5, 5, 2, 2};
        int ek[5] = '{2, 3, 4, 8, 9};
        int dk[$];
        px.delete(); py.delete(); pc.delete(); pk.delete();
        @(negedge clk);
        start = 1'b1; x0 = 9'd0; y0 = 8'd0; x1 = 9'd2; y1 = 8'd0; i_colour = 3'd5; plot_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin x0 = 9'd5; y0 = 8'd5; x1 = 9'd5; y1 = 8'd6; i_colour = 3'd2; end
            if (c == 7) start = 1'b0;
            if (plot && plot_ready) begin
                px.push_back(int'(x)); py.push_back(int'(y)); pc.push_back(int'(o_colour)); pk.push_back(c);
            end
            if (done) dk.push_back(c);
        end
        tests++; if (px.size() !== 5) begin fails++; $display("FAIL b2b_count got %0d want 5", px.size()); end
        for (int i = 0; i < px.size() && i < 5; i++) begin
            tests++;
            if (px[i] !== ex[i] || py[i] !== ey[i] || pc[i] !== ec[i] || pk[i] !== ek[i]) begin
                fails++; $display("FAIL b2b_pix%0d got (%0d,%0d,c%0d)@%0d want (%0d,%0d,c%0d)@%0d", i, px[i], py[i], pc[i], pk[i], ex[i], ey[i], ec[i], ek[i]);
            end
        end
        tests++; if (dk.size() !== 2 || dk[0] !== 5 || dk[1] !== 10) begin fails++; $display("FAIL b2b_done got %0d pulses first=%0d want 2 pulses at 5,10", dk.size(), dk.size() ? dk[0] : -1); end
    endtask

    initial begin
        test_reset;
        test_horizontal;
        test_steep;
        test_reverse;
        test_backpressure;
        test_degenerate;
        test_reset_mid_line;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
